// File: rtl/tval_buffer_pkg.sv
// rtl/tval_buffer_pkg.sv - shared SqN/provider/state types for the trap-value buffer
package tval_buffer_pkg;

  localparam int SQN_W      = 7;
  localparam int PKG_TVAL_W = 32;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic                  valid;
    SqN                    sqN;
    logic [PKG_TVAL_W-1:0] tval;
  } TValProv;

  typedef struct packed {
    logic [PKG_TVAL_W-1:0] tval;
  } TValState;

  typedef struct packed {
    logic [PKG_TVAL_W-1:0] tval;
    SqN                    sqN;
    logic                  retire;
    logic                  live;
  } TValEntry;

  // Wrap-safe age order: a is older than b when (a - b) is negative in SqN width.
  function automatic logic sqn_older(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

endpackage

// File: rtl/tval_buffer_if.sv
// rtl/tval_buffer_if.sv - provider/branch/commit inputs and trap-facing outputs of tval_buffer
interface tval_buffer_if
  import tval_buffer_pkg::*;
#(
  parameter int NUM_TVAL_PROVS = 2,
  parameter int TVAL_W         = 32
);

  BranchProv          IN_branch;
  SqN                 IN_commitSqN;
  TValProv            IN_tvalProvs [NUM_TVAL_PROVS];
  SqN                 IN_lookupSqN;
  TValState           OUT_tvalState;
  logic               OUT_lookupHit;
  logic [TVAL_W-1:0]  OUT_lookupTVal;
  logic               OUT_overflow;

  modport master (
    output IN_branch, IN_commitSqN, IN_tvalProvs, IN_lookupSqN,
    input  OUT_tvalState, OUT_lookupHit, OUT_lookupTVal, OUT_overflow
  );

  modport slave (
    input  IN_branch, IN_commitSqN, IN_tvalProvs, IN_lookupSqN,
    output OUT_tvalState, OUT_lookupHit, OUT_lookupTVal, OUT_overflow
  );

endinterface

// File: rtl/tval_age_select.sv
// rtl/tval_age_select.sv - oldest-of-N (or youngest-of-N) reduction over {valid, sqN}
module tval_age_select
  import tval_buffer_pkg::*;
#(
  parameter int N        = 2,
  parameter bit YOUNGEST = 1'b0,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            valid,
  input  logic [N-1:0][SQN_W-1:0] sqn,
  output logic [IDX_W-1:0]        idx,
  output logic                    found
);

  // Strict compare keeps the lowest index on equal SqNs.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        if (!found || (YOUNGEST ? sqn_older(sqn[idx], sqn[i]) : sqn_older(sqn[i], sqn[idx]))) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tval_buffer.sv
// rtl/tval_buffer.sv - multi-entry trap-value store keyed by SqN with flush, delayed retire and lookup
// TVAL_W must not exceed PKG_TVAL_W; stored tvals are zero-extended to the package width.
module tval_buffer
  import tval_buffer_pkg::*;
#(
  parameter int NUM_TVAL_PROVS = 2,
  parameter int DEPTH          = 4,
  parameter int TVAL_W         = 32
) (
  input logic         clk,
  input logic         rst,
  tval_buffer_if.slave bus
);

  localparam int P      = NUM_TVAL_PROVS;
  localparam int PIDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int EIDX_W = $clog2(DEPTH);

  TValEntry ent_q [DEPTH];
  TValEntry ent_d [DEPTH];
  TValState state_q;
  logic     ovf_q, overflow_d;

  logic [P-1:0]                   keep_raw, prov_keep, prov_merge, prov_alloc;
  logic [P-1:0][SQN_W-1:0]        prov_sqn;
  logic [P-1:0][PKG_TVAL_W-1:0]   prov_tval;
  logic [P-1:0][EIDX_W-1:0]       merge_slot;
  logic [DEPTH-1:0]               flush_hit, merged, base_occ, nxt_live;
  logic [DEPTH-1:0][SQN_W-1:0]    ent_sqn, nxt_sqn;
  logic [P-1:0]                   step_wr, step_ovf;
  logic [P-1:0][EIDX_W-1:0]       step_slot;
  logic [P-1:0][PIDX_W-1:0]       step_prov;
  logic [EIDX_W-1:0]              oldest_idx;
  logic                           oldest_ok;

  // Provider filter, same-SqN dedupe (lowest index wins) and merge into live entries.
  always_comb begin
    keep_raw   = '0;
    prov_keep  = '0;
    prov_merge = '0;
    merge_slot = '0;
    flush_hit  = '0;
    merged     = '0;
    base_occ   = '0;
    prov_sqn   = '0;
    prov_tval  = '0;
    ent_sqn    = '0;
    for (int p = 0; p < P; p++) begin
      prov_sqn[p]  = bus.IN_tvalProvs[p].sqN;
      prov_tval[p] = PKG_TVAL_W'(bus.IN_tvalProvs[p].tval[TVAL_W-1:0]);
      keep_raw[p]  = bus.IN_tvalProvs[p].valid &&
                     !(bus.IN_branch.taken && !sqn_older(prov_sqn[p], bus.IN_branch.sqN));
    end
    for (int p = 0; p < P; p++) begin
      prov_keep[p] = keep_raw[p];
      for (int q = 0; q < p; q++)
        if (keep_raw[q] && prov_sqn[q] == prov_sqn[p]) prov_keep[p] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_sqn[i]   = ent_q[i].sqN;
      flush_hit[i] = bus.IN_branch.taken && ent_q[i].live && sqn_older(bus.IN_branch.sqN, ent_q[i].sqN);
    end
    for (int p = 0; p < P; p++)
      for (int i = 0; i < DEPTH; i++)
        if (prov_keep[p] && ent_q[i].live && !flush_hit[i] && ent_q[i].sqN == prov_sqn[p]) begin
          prov_merge[p] = 1'b1;
          merge_slot[p] = EIDX_W'(i);
          merged[i]     = 1'b1;
        end
    for (int i = 0; i < DEPTH; i++)
      base_occ[i] = ent_q[i].live && !flush_hit[i] && !(ent_q[i].retire && !merged[i]);
  end

  assign prov_alloc = prov_keep & ~prov_merge;

  // One allocation step per provider, oldest first; each step sees the slots taken by earlier steps.
  for (genvar k = 0; k < P; k++) begin : g_step
    logic [P-1:0]                rem_in, rem_out;
    logic [DEPTH-1:0]            occ_in, occ_out;
    logic [DEPTH-1:0][SQN_W-1:0] sqn_in, sqn_out;
    logic [PIDX_W-1:0]           pick;
    logic                        pick_ok;
    logic [EIDX_W-1:0]           victim, wr_slot;
    logic                        victim_ok, wr_en, ovf;

    if (k == 0) begin : g_first
      assign rem_in = prov_alloc;
      assign occ_in = base_occ;
      assign sqn_in = ent_sqn;
    end else begin : g_next
      assign rem_in = g_step[k-1].rem_out;
      assign occ_in = g_step[k-1].occ_out;
      assign sqn_in = g_step[k-1].sqn_out;
    end

    tval_age_select #(.N(P), .YOUNGEST(1'b0)) u_pick (
      .valid(rem_in), .sqn(prov_sqn), .idx(pick), .found(pick_ok)
    );
    tval_age_select #(.N(DEPTH), .YOUNGEST(1'b1)) u_victim (
      .valid(occ_in), .sqn(sqn_in), .idx(victim), .found(victim_ok)
    );

    always_comb begin
      wr_en   = 1'b0;
      ovf     = 1'b0;
      wr_slot = '0;
      rem_out = rem_in;
      occ_out = occ_in;
      sqn_out = sqn_in;
      if (pick_ok) begin
        rem_out[pick] = 1'b0;
        if (!(&occ_in)) begin
          for (int i = DEPTH - 1; i >= 0; i--)
            if (!occ_in[i]) wr_slot = EIDX_W'(i);
          wr_en = 1'b1;
        end else begin
          ovf = 1'b1;
          if (victim_ok && sqn_older(prov_sqn[pick], sqn_in[victim])) begin
            wr_en   = 1'b1;
            wr_slot = victim;
          end
        end
        if (wr_en) begin
          occ_out[wr_slot] = 1'b1;
          sqn_out[wr_slot] = prov_sqn[pick];
        end
      end
    end

    assign step_wr[k]   = wr_en;
    assign step_ovf[k]  = ovf;
    assign step_slot[k] = wr_slot;
    assign step_prov[k] = pick;
  end

  // Retire flags arm while commit is past the entry and fire one cycle later unless a merge re-arms.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].live) begin
        if (flush_hit[i] || (ent_q[i].retire && !merged[i])) begin
          ent_d[i].live   = 1'b0;
          ent_d[i].retire = 1'b0;
        end else if (sqn_older(ent_q[i].sqN, bus.IN_commitSqN)) begin
          ent_d[i].retire = 1'b1;
        end
      end
    end
    for (int p = 0; p < P; p++)
      if (prov_merge[p]) begin
        ent_d[merge_slot[p]].tval   = prov_tval[p];
        ent_d[merge_slot[p]].retire = 1'b0;
      end
    for (int k = 0; k < P; k++)
      if (step_wr[k])
        ent_d[step_slot[k]] = '{tval: prov_tval[step_prov[k]], sqN: prov_sqn[step_prov[k]],
                                retire: 1'b0, live: 1'b1};
    overflow_d = |step_ovf;
  end

  always_comb begin
    nxt_live = '0;
    nxt_sqn  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_live[i] = ent_d[i].live;
      nxt_sqn[i]  = ent_d[i].sqN;
    end
  end

  tval_age_select #(.N(DEPTH), .YOUNGEST(1'b0)) u_oldest (
    .valid(nxt_live), .sqn(nxt_sqn), .idx(oldest_idx), .found(oldest_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      state_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      if (oldest_ok) state_q <= '{tval: ent_d[oldest_idx].tval};
      ovf_q <= overflow_d;
    end
  end

  always_comb begin
    bus.OUT_lookupHit  = 1'b0;
    bus.OUT_lookupTVal = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].live && ent_q[i].sqN == bus.IN_lookupSqN) begin
        bus.OUT_lookupHit  = 1'b1;
        bus.OUT_lookupTVal = ent_q[i].tval[TVAL_W-1:0];
      end
  end

  assign bus.OUT_tvalState = state_q;
  assign bus.OUT_overflow  = ovf_q;

endmodule
